ascon_state_serializer: RTL
===========================

ASCON_STATE_SERIALIZER -- requirements
Module: ascon_state_serializer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 5, number of state words emitted per accepted state (legal 1..5; S0..S{NUM_OUT-1}).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_valid  input  1  upstream state valid.
REQ-005 SHALL have port s_ready  output  1  block can accept a state.
REQ-006 SHALL have port s_state  input  320 (ascon_state_t)  full Ascon state; index 0 = S0.
REQ-007 SHALL have port m_valid  output  1  output word valid.
REQ-008 SHALL have port m_ready  input  1  downstream accepts word.
REQ-009 SHALL have port m_word  output  64 (ascon_word_t)  current state word.
REQ-010 SHALL have port m_idx  output  3  index of m_word within the state (0..4).
REQ-011 SHALL have port m_last  output  1  high with the word at index NUM_OUT-1.
REQ-012 SHALL have port busy  output  1  high whenever the block is not in IDLE.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, SEND.
REQ-014 In IDLE, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-015 On s_valid && s_ready, SHALL register all 320 bits of s_state, clear the word counter to 0, enter SEND next cycle.
REQ-016 In SEND, m_valid SHALL be 1, s_ready SHALL be 0, m_word SHALL equal registered word[counter], m_idx SHALL equal counter.
REQ-017 Words SHALL be emitted in ascending order S0 first; words at index >= NUM_OUT SHALL never be emitted.
REQ-018 On m_valid && m_ready with counter < NUM_OUT-1, counter SHALL increment by 1.
REQ-019 On m_valid && m_ready with counter == NUM_OUT-1, SHALL return to IDLE; s_ready SHALL be 1 the following cycle.
REQ-020 While m_valid && !m_ready, m_word, m_idx, m_last SHALL hold stable (AXI-stream stall rule).
REQ-021 m_valid SHALL NOT depend combinationally on m_ready; s_ready SHALL NOT depend combinationally on s_valid.
REQ-022 Latency: first word valid exactly 1 cycle after accept handshake; with m_ready held 1, a state takes NUM_OUT+1 cycles (accept + NUM_OUT words).
REQ-023 Changes to s_state after acceptance SHALL NOT affect words being emitted.
REQ-024 m_last SHALL be 0 in IDLE; with NUM_OUT=1 it SHALL be 1 on the single word.
REQ-025 Counter SHALL never exceed NUM_OUT-1 (no wrap-around in SEND).

Reset
REQ-026 While rst is 1, SHALL force IDLE, counter 0, state register 0, asynchronously.
REQ-027 Output reset values: s_ready 0 while rst high, 1 from first clock after deassertion; m_valid 0, m_word 0, m_idx 0, m_last 0, busy 0.
REQ-028 Reset mid-SEND SHALL abort the transfer immediately; no further words of that state SHALL be emitted.

Structure
REQ-029 ascon_word_t, ascon_state_t, WORD_WIDTH, NUM_WORDS, STATE_WIDTH SHALL come from ascon_pkg; the FSM enum type and a 3-bit word-index typedef SHALL be added to ascon_pkg.
REQ-030 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-031 Basic: NUM_OUT=5, state S0..S4 = 64'h0000_0000_0000_0000..64'h4444_4444_4444_4444 (Sk = k repeated), m_ready=1 -> words S0..S4 on 5 consecutive cycles, m_idx 0..4, m_last only on S4, s_ready high again cycle 7.
REQ-032 Backpressure: m_ready=0 for 3 cycles at idx 2 -> m_word stays 64'h2222_2222_2222_2222, m_idx 2 stable, then sequence resumes without loss or duplication.
REQ-033 Rate mode: NUM_OUT=1, S0=64'h80400C0600000000 -> single word with m_last=1, return to IDLE; NUM_OUT=2 -> only S0,S1.
REQ-034 Input isolation: change s_state and hold s_valid=1 during SEND -> s_ready stays 0, emitted words match originally captured state, second state accepted only after m_last handshake.
REQ-035 Reset mid-operation: assert rst after idx 1 handshake -> m_valid 0, busy 0 same cycle (async); after release, new state emits from S0.
REQ-036 Random: 1000 states, random s_valid/m_ready -> scoreboard matches all words in order, no handshake violations.

Source files
------------

// File: rtl/ascon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascon_pkg                                                        |
// | Shared Ascon state types plus serializer FSM and index types.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ascon_pkg;

   localparam int WORD_WIDTH  = 64;
   localparam int NUM_WORDS   = 5;
   localparam int STATE_WIDTH = WORD_WIDTH * NUM_WORDS;

   typedef logic [WORD_WIDTH-1:0]                 ascon_word_t;
   // Index 0 of the packed array is S0, occupying bits [63:0].
   typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  ascon_state_t;
   typedef logic [2:0]                            word_idx_t;

   typedef enum logic [0:0] {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/ascon_state_serializer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascon_state_serializer_if                                        |
// | State-in / word-out stream bundle for the state serializer.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface ascon_state_serializer_if;
   import ascon_pkg::*;

   logic         s_valid;
   logic         s_ready;
   ascon_state_t s_state;
   logic         m_valid;
   logic         m_ready;
   ascon_word_t  m_word;
   word_idx_t    m_idx;
   logic         m_last;

   // The serializer itself sits on the slave side of this bundle.
   modport slave (
      input  s_valid, s_state, m_ready,
      output s_ready, m_valid, m_word, m_idx, m_last
   );

   modport master (
      output s_valid, s_state, m_ready,
      input  s_ready, m_valid, m_word, m_idx, m_last
   );

endinterface
`default_nettype wire

// File: rtl/ascon_state_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascon_state_serializer                                           |
// | Captures a 320-bit Ascon state, emits S0..S{NUM_OUT-1} in order. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ascon_state_serializer
   import ascon_pkg::*;
#(
   parameter int NUM_OUT = 5
) (
   input  wire logic               clk,
   input  wire logic               rst,
   ascon_state_serializer_if.slave bus,
   output logic                    busy
);

   localparam word_idx_t LAST_IDX = word_idx_t'(NUM_OUT - 1);

   ser_state_e   r_state;
   word_idx_t    r_cnt;
   ascon_state_t r_data;
   logic         r_s_ready;

   // s_ready has its own register so it stays low while rst is high
   // and only rises on the first clock after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= SER_IDLE;
         r_cnt     <= '0;
         r_data    <= '0;
         r_s_ready <= 1'b0;
      end else begin
         case (r_state)
            SER_IDLE: begin
               if (bus.s_valid && r_s_ready) begin
                  r_data    <= bus.s_state;
                  r_cnt     <= '0;
                  r_s_ready <= 1'b0;
                  r_state   <= SER_SEND;
               end else begin
                  r_s_ready <= 1'b1;
               end
            end
            SER_SEND: begin
               if (bus.m_ready) begin
                  if (r_cnt == LAST_IDX) begin
                     r_cnt     <= '0;
                     r_s_ready <= 1'b1;
                     r_state   <= SER_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            default: begin
               r_state <= SER_IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready = r_s_ready;
   assign bus.m_valid = (r_state == SER_SEND);
   assign bus.m_word  = r_data[r_cnt];
   assign bus.m_idx   = r_cnt;
   assign bus.m_last  = (r_state == SER_SEND) && (r_cnt == LAST_IDX);
   assign busy        = (r_state == SER_SEND);

endmodule
`default_nettype wire
